// File: rtl/posicionador_minas.sv
// -----------------------------------------------------------------------------
// posicionador_minas
//
// Writer side of the mine matrix. On a start pulse it captures the game setup,
// scatters mines pseudo-randomly over the active largura x altura field while
// keeping the 3x3 block around the first-opened cell clear, and then streams
// one record per cell (mine bit + neighbour count) in row-major order into the
// matrix storage that the display path reads.
//
// Ports:
//   clk_50          system clock (50 MHz)
//   reset           synchronous reset, active-low
//   start           one-cycle generation request (accepted only when idle)
//   largura/altura  field width/height in cells
//   max_minas       requested number of mines (clamped to cells-9)
//   seed            LFSR seed (zero selects LFSR_SEED_DEF)
//   excl_x/excl_y   first-opened cell, centre of the mine-free 3x3 block
//   busy            generation in progress
//   done            one-cycle pulse after the last record is written
//   wr_en/wr_x/wr_y record write strobe and cell address
//   wr_mina/wr_viz  record contents: mine bit and neighbour mine count
//   minas_colocadas mines placed by the last completed generation
// -----------------------------------------------------------------------------
module posicionador_minas #(
   parameter int          MAX_W         = 16,
   parameter int          MAX_H         = 12,
   parameter int          COORD_W       = 4,
   parameter logic [15:0] LFSR_SEED_DEF = 16'hACE1
) (
   input  logic               clk_50,
   input  logic               reset,
   input  logic               start,
   input  logic [7:0]         largura,
   input  logic [7:0]         altura,
   input  logic [9:0]         max_minas,
   input  logic [15:0]        seed,
   input  logic [COORD_W-1:0] excl_x,
   input  logic [COORD_W-1:0] excl_y,
   output logic               busy,
   output logic               done,
   output logic               wr_en,
   output logic [COORD_W-1:0] wr_x,
   output logic [COORD_W-1:0] wr_y,
   output logic               wr_mina,
   output logic [3:0]         wr_viz,
   output logic [9:0]         minas_colocadas
);

   localparam int CELLS = MAX_W * MAX_H;
   localparam int IDX_W = $clog2(CELLS);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      PLACE = 3'd2,
      COUNT = 3'd3,
      FIN   = 3'd4
   } state_t;

   state_t             state;
   state_t             state_next;

   logic [15:0]        lfsr;
   logic [15:0]        lfsr_next;
   logic [CELLS-1:0]   bitmap;
   logic [7:0]         larg_q;
   logic [7:0]         alt_q;
   logic [COORD_W-1:0] ex_q;
   logic [COORD_W-1:0] ey_q;
   logic [9:0]         alvo_q;
   logic [9:0]         placed;
   logic [COORD_W-1:0] scan_x;
   logic [COORD_W-1:0] scan_y;

   logic [15:0]        area;
   logic [15:0]        lim;
   logic [9:0]         alvo_calc;
   logic [COORD_W-1:0] cx;
   logic [COORD_W-1:0] cy;
   logic [IDX_W-1:0]   cand_idx;
   logic               cand_ok;
   logic               row_end;
   logic               last_cell;

   // Bitmap lookup that treats anything outside the storage as empty.
   function automatic logic bit_at(input logic [CELLS-1:0] map,
                                   input int x, input int y);
      logic r;
      r = 1'b0;
      if (x >= 0 && x < MAX_W && y >= 0 && y < MAX_H)
         r = map[y*MAX_W + x];
      return r;
   endfunction

   // Number of mines among the 8 neighbours of (x, y) inside the w x h field.
   function automatic logic [3:0] conta_viz(input logic [CELLS-1:0] map,
                                            input int x, input int y,
                                            input int w, input int h);
      logic [3:0] n;
      int         nx;
      int         ny;
      n = 4'd0;
      for (int dy = -1; dy <= 1; dy++) begin
         for (int dx = -1; dx <= 1; dx++) begin
            nx = x + dx;
            ny = y + dy;
            if (!(dx == 0 && dy == 0) && nx >= 0 && nx < w && ny >= 0 && ny < h) begin
               if (bit_at(map, nx, ny))
                  n = n + 4'd1;
            end
         end
      end
      return n;
   endfunction

   // Target count: never more mines than cells outside the safe 3x3 block.
   always_comb begin
      area      = 16'(largura) * 16'(altura);
      lim       = area - 16'd9;
      alvo_calc = 10'd0;
      if (area >= 16'd9) begin
         if (16'(max_minas) < lim)
            alvo_calc = max_minas;
         else
            alvo_calc = lim[9:0];
      end
   end

   // Galois LFSR, right shift, taps x^16+x^14+x^13+x^11+1.
   assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   assign cx = lfsr[COORD_W-1:0];
   assign cy = lfsr[2*COORD_W-1:COORD_W];

   always_comb begin
      int cx_i;
      int cy_i;
      int dx;
      int dy;
      logic in_field;
      logic near;
      cx_i     = int'(cx);
      cy_i     = int'(cy);
      dx       = cx_i - int'(ex_q);
      dy       = cy_i - int'(ey_q);
      in_field = (cx_i < int'(larg_q)) && (cy_i < int'(alt_q)) &&
                 (cx_i < MAX_W) && (cy_i < MAX_H);
      near     = (dx >= -1) && (dx <= 1) && (dy >= -1) && (dy <= 1);
      cand_idx = in_field ? IDX_W'(cy_i*MAX_W + cx_i) : '0;
      cand_ok  = in_field && !near && !bitmap[cand_idx];
   end

   assign row_end   = (8'(scan_x) == larg_q - 8'd1);
   assign last_cell = row_end && (8'(scan_y) == alt_q - 8'd1);

   // State register
   always_ff @(posedge clk_50) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next state and outputs
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      wr_en      = 1'b0;
      wr_x       = '0;
      wr_y       = '0;
      wr_mina    = 1'b0;
      wr_viz     = 4'd0;
      case (state)
         IDLE: begin
            if (start)
               state_next = INIT;
         end
         INIT: begin
            busy       = 1'b1;
            state_next = (alvo_q == 10'd0) ? COUNT : PLACE;
         end
         PLACE: begin
            busy = 1'b1;
            if (cand_ok && (placed + 10'd1 == alvo_q))
               state_next = COUNT;
         end
         COUNT: begin
            busy    = 1'b1;
            wr_en   = 1'b1;
            wr_x    = scan_x;
            wr_y    = scan_y;
            wr_mina = bit_at(bitmap, int'(scan_x), int'(scan_y));
            wr_viz  = conta_viz(bitmap, int'(scan_x), int'(scan_y),
                                int'(larg_q), int'(alt_q));
            if (last_cell)
               state_next = FIN;
         end
         FIN: begin
            done       = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath: capture, placement, scan counters
   always_ff @(posedge clk_50) begin
      if (!reset) begin
         lfsr            <= LFSR_SEED_DEF;
         bitmap          <= '0;
         placed          <= 10'd0;
         alvo_q          <= 10'd0;
         larg_q          <= 8'd0;
         alt_q           <= 8'd0;
         ex_q            <= '0;
         ey_q            <= '0;
         scan_x          <= '0;
         scan_y          <= '0;
         minas_colocadas <= 10'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  lfsr   <= (seed == 16'd0) ? LFSR_SEED_DEF : seed;
                  larg_q <= largura;
                  alt_q  <= altura;
                  ex_q   <= excl_x;
                  ey_q   <= excl_y;
                  alvo_q <= alvo_calc;
               end
            end
            INIT: begin
               bitmap <= '0;
               placed <= 10'd0;
               scan_x <= '0;
               scan_y <= '0;
            end
            PLACE: begin
               lfsr <= lfsr_next;
               if (cand_ok) begin
                  bitmap[cand_idx] <= 1'b1;
                  placed           <= placed + 10'd1;
               end
            end
            COUNT: begin
               if (row_end) begin
                  scan_x <= '0;
                  scan_y <= scan_y + 1'b1;
               end else begin
                  scan_x <= scan_x + 1'b1;
               end
               if (last_cell)
                  minas_colocadas <= alvo_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_posicionador_minas.sv
module tb_posicionador_minas;

   logic        clk_50 = 1'b0;
   logic        reset  = 1'b0;
   logic        start  = 1'b0;
   logic [7:0]  largura = 8'd4;
   logic [7:0]  altura  = 8'd3;
   logic [9:0]  max_minas = 10'd0;
   logic [15:0] seed = 16'd0;
   logic [3:0]  excl_x = 4'd0;
   logic [3:0]  excl_y = 4'd0;
   logic        busy, done, wr_en, wr_mina;
   logic [3:0]  wr_x, wr_y, wr_viz;
   logic [9:0]  minas_colocadas;

   posicionador_minas dut (
      .clk_50(clk_50), .reset(reset), .start(start),
      .largura(largura), .altura(altura), .max_minas(max_minas),
      .seed(seed), .excl_x(excl_x), .excl_y(excl_y),
      .busy(busy), .done(done), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
      .wr_mina(wr_mina), .wr_viz(wr_viz), .minas_colocadas(minas_colocadas)
   );

   always #10 clk_50 = ~clk_50;

   int checks = 0;
   int errors = 0;

   // Results of the most recent generation run
   int   nwr, ndone, lat, first_wr, last_wr, order_err;
   logic busy1;
   logic       rec_m [0:191];
   logic [3:0] rec_v [0:191];
   logic       ref_m [0:191];
   logic [3:0] ref_v [0:191];
   int   ref_lat;

   function automatic int sw_viz(int x, int y, int w, int h);
      int n;
      n = 0;
      for (int dy = -1; dy <= 1; dy++)
         for (int dx = -1; dx <= 1; dx++)
            if (!(dx == 0 && dy == 0) && x+dx >= 0 && x+dx < w && y+dy >= 0 && y+dy < h)
               if (rec_m[(y+dy)*16 + x+dx] === 1'b1) n++;
      return n;
   endfunction

   function automatic int viz_errors(int w, int h);
      int e;
      e = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            if (rec_v[y*16+x] !== 4'(sw_viz(x, y, w, h))) e++;
      return e;
   endfunction

   function automatic int mine_count(int w, int h);
      int n;
      n = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            if (rec_m[y*16+x] === 1'b1) n++;
      return n;
   endfunction

   function automatic int zone_mines(int w, int h, int ex, int ey);
      int n;
      n = 0;
      for (int y = 0; y < h; y++)
         for (int x = 0; x < w; x++)
            if (x >= ex-1 && x <= ex+1 && y >= ey-1 && y <= ey+1 && rec_m[y*16+x] === 1'b1) n++;
      return n;
   endfunction

   // Pulse start with the given setup, scramble the inputs after acceptance,
   // and record the write stream. inj >= 0 pulses start again after that many writes.
   task automatic run_gen(input int w, input int h, input int mm, input logic [15:0] sd,
                          input int ex, input int ey, input int inj);
      int  ex_x, ex_y, post;
      bit  injected, got_done;
      @(posedge clk_50); #1;
      largura = 8'(w); altura = 8'(h); max_minas = 10'(mm); seed = sd;
      excl_x = 4'(ex); excl_y = 4'(ey); start = 1'b1;
      @(posedge clk_50); #1;
      start = 1'b0;
      largura = 8'd5; altura = 8'd7; max_minas = 10'd1; seed = 16'hFFFF;
      excl_x = 4'd3; excl_y = 4'd3;
      for (int i = 0; i < 192; i++) begin rec_m[i] = 1'bx; rec_v[i] = 4'hx; end
      nwr = 0; ndone = 0; lat = -1; first_wr = -1; last_wr = -1; order_err = 0;
      busy1 = 1'b0; post = 0; injected = 0; got_done = 0;
      for (int k = 1; k <= 6000 && post < 6; k++) begin
         @(negedge clk_50);
         if (start) start = 1'b0;
         if (k == 1) busy1 = busy;
         if (wr_en === 1'b1) begin
            ex_x = nwr % w; ex_y = nwr / w;
            if (nwr >= w*h || wr_x !== 4'(ex_x) || wr_y !== 4'(ex_y)) order_err++;
            else begin rec_m[ex_y*16+ex_x] = wr_mina; rec_v[ex_y*16+ex_x] = wr_viz; end
            if (first_wr < 0) first_wr = k;
            last_wr = k;
            nwr++;
            if (inj >= 0 && !injected && nwr == inj) begin start = 1'b1; injected = 1; end
         end
         if (done === 1'b1) begin
            ndone++;
            if (!got_done) lat = k;
            got_done = 1;
         end
         if (got_done) post++;
      end
      start = 1'b0;
      checks++;
      if (!got_done) begin
         errors++;
         $display("FAIL done_timeout: no done within cycle budget (writes=%0d)", nwr);
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      repeat (3) @(posedge clk_50);
      @(negedge clk_50);
      checks++;
      if ({busy, done, wr_en, wr_mina, wr_x, wr_y, wr_viz, minas_colocadas} !== 24'd0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b done=%b wr_en=%b mina=%b x=%0d y=%0d viz=%0d placed=%0d, required all 0",
                  busy, done, wr_en, wr_mina, wr_x, wr_y, wr_viz, minas_colocadas);
      end
      reset = 1'b1;
   endtask

   task automatic test_small;
      run_gen(4, 3, 3, 16'h1234, 0, 0, -1);
      checks++; if (nwr !== 12) begin errors++; $display("FAIL small_writes: got %0d, required 12", nwr); end
      checks++; if (order_err !== 0) begin errors++; $display("FAIL small_order: %0d bad addresses, required 0", order_err); end
      checks++; if (last_wr - first_wr + 1 !== 12) begin errors++; $display("FAIL small_gapless: span %0d, required 12", last_wr-first_wr+1); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL small_done_count: got %0d, required 1", ndone); end
      checks++; if (lat !== last_wr + 1) begin errors++; $display("FAIL small_done_timing: done at %0d, required %0d", lat, last_wr+1); end
      checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL small_busy_init: got %b, required 1", busy1); end
      checks++; if (minas_colocadas !== 10'd3) begin errors++; $display("FAIL small_placed: got %0d, required 3", minas_colocadas); end
      checks++; if (mine_count(4, 3) !== 3) begin errors++; $display("FAIL small_mines: got %0d, required 3", mine_count(4, 3)); end
      checks++; if (zone_mines(4, 3, 0, 0) !== 0) begin errors++; $display("FAIL small_safe_zone: got %0d, required 0", zone_mines(4, 3, 0, 0)); end
   endtask

   task automatic test_clamp;
      run_gen(4, 3, 50, 16'h5A5A, 2, 1, -1);
      checks++; if (minas_colocadas !== 10'd3) begin errors++; $display("FAIL clamp_placed: got %0d, required 3", minas_colocadas); end
      checks++; if (mine_count(4, 3) !== 3) begin errors++; $display("FAIL clamp_mines: got %0d, required 3", mine_count(4, 3)); end
      checks++; if (zone_mines(4, 3, 2, 1) !== 0) begin errors++; $display("FAIL clamp_safe_zone: got %0d, required 0", zone_mines(4, 3, 2, 1)); end
      checks++; if (viz_errors(4, 3) !== 0) begin errors++; $display("FAIL clamp_viz: %0d wrong counts, required 0", viz_errors(4, 3)); end
   endtask

   task automatic test_no_mines;
      int nz;
      run_gen(16, 12, 0, 16'h0BAD, 4, 4, -1);
      nz = 0;
      for (int i = 0; i < 192; i++) if (rec_m[i] !== 1'b0 || rec_v[i] !== 4'd0) nz++;
      checks++; if (nwr !== 192) begin errors++; $display("FAIL empty_writes: got %0d, required 192", nwr); end
      checks++; if (nz !== 0) begin errors++; $display("FAIL empty_records: %0d nonzero records, required 0", nz); end
      checks++; if (first_wr !== 2) begin errors++; $display("FAIL empty_first_write: cycle %0d, required 2", first_wr); end
      checks++; if (lat !== 194) begin errors++; $display("FAIL empty_latency: got %0d, required 194", lat); end
      checks++; if (minas_colocadas !== 10'd0) begin errors++; $display("FAIL empty_placed: got %0d, required 0", minas_colocadas); end
   endtask

   task automatic test_seed_zero;
      int diff;
      run_gen(16, 12, 38, 16'h0000, 7, 5, -1);
      checks++; if (mine_count(16, 12) !== 38) begin errors++; $display("FAIL seed0_mines: got %0d, required 38", mine_count(16, 12)); end
      checks++; if (rec_m[5*16+7] !== 1'b0 || rec_v[5*16+7] !== 4'd0) begin errors++; $display("FAIL seed0_first_cell: mina=%b viz=%0d, required 0/0", rec_m[5*16+7], rec_v[5*16+7]); end
      checks++; if (viz_errors(16, 12) !== 0) begin errors++; $display("FAIL seed0_viz: %0d wrong counts, required 0", viz_errors(16, 12)); end
      checks++; if (minas_colocadas !== 10'd38) begin errors++; $display("FAIL seed0_placed: got %0d, required 38", minas_colocadas); end
      for (int i = 0; i < 192; i++) begin ref_m[i] = rec_m[i]; ref_v[i] = rec_v[i]; end
      ref_lat = lat;
      run_gen(16, 12, 38, 16'hACE1, 7, 5, -1);
      diff = 0;
      for (int i = 0; i < 192; i++) if (rec_m[i] !== ref_m[i] || rec_v[i] !== ref_v[i]) diff++;
      checks++; if (diff !== 0) begin errors++; $display("FAIL seed_default_stream: %0d differing records, required 0", diff); end
      checks++; if (lat !== ref_lat) begin errors++; $display("FAIL seed_default_latency: got %0d, required %0d", lat, ref_lat); end
   endtask

   task automatic test_reset_mid_place;
      int diff, stray;
      @(posedge clk_50); #1;
      largura = 8'd16; altura = 8'd12; max_minas = 10'd38; seed = 16'hACE1;
      excl_x = 4'd7; excl_y = 4'd5; start = 1'b1;
      @(posedge clk_50); #1;
      start = 1'b0;
      repeat (4) @(negedge clk_50);
      checks++; if (busy !== 1'b1 || wr_en !== 1'b0) begin errors++; $display("FAIL abort_in_place: busy=%b wr_en=%b, required 1/0", busy, wr_en); end
      reset = 1'b0;
      @(negedge clk_50);
      checks++; if (busy !== 1'b0 || wr_en !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_outputs: busy=%b wr_en=%b done=%b, required 0/0/0", busy, wr_en, done); end
      reset = 1'b1;
      stray = 0;
      repeat (20) begin @(negedge clk_50); if (wr_en !== 1'b0 || busy !== 1'b0) stray++; end
      checks++; if (stray !== 0) begin errors++; $display("FAIL abort_idle: %0d active cycles, required 0", stray); end
      run_gen(16, 12, 38, 16'hACE1, 7, 5, -1);
      diff = 0;
      for (int i = 0; i < 192; i++) if (rec_m[i] !== ref_m[i] || rec_v[i] !== ref_v[i]) diff++;
      checks++; if (diff !== 0) begin errors++; $display("FAIL abort_rerun_stream: %0d differing records, required 0", diff); end
      checks++; if (lat !== ref_lat) begin errors++; $display("FAIL abort_rerun_latency: got %0d, required %0d", lat, ref_lat); end
   endtask

   task automatic test_back_to_back;
      run_gen(4, 3, 3, 16'h1234, 0, 0, 5);
      checks++; if (nwr !== 12) begin errors++; $display("FAIL restart_writes: got %0d, required 12", nwr); end
      checks++; if (ndone !== 1) begin errors++; $display("FAIL restart_done_count: got %0d, required 1", ndone); end
      checks++; if (order_err !== 0) begin errors++; $display("FAIL restart_order: %0d bad addresses, required 0", order_err); end
   endtask

   initial begin
      test_reset();
      test_small();
      test_clamp();
      test_no_mines();
      test_seed_zero();
      test_reset_mid_place();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
